// File: rtl/riscv_ctrl_pkg.sv
// Shared RV32I decode helpers and the in-flight producer record used by the hazard/forwarding controller.
package riscv_ctrl_pkg;

   localparam logic [4:0] OP_R     = 5'b01100;
   localparam logic [4:0] OP_I     = 5'b00100;
   localparam logic [4:0] OP_L     = 5'b00000;
   localparam logic [4:0] OP_S     = 5'b01000;
   localparam logic [4:0] OP_B     = 5'b11000;
   localparam logic [4:0] OP_JALR  = 5'b11001;
   localparam logic [4:0] OP_JAL   = 5'b11011;
   localparam logic [4:0] OP_AUIPC = 5'b00101;
   localparam logic [4:0] OP_LUI   = 5'b01101;
   localparam logic [4:0] OP_CSR   = 5'b11100;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       is_load;
   } trk_entry_t;

   localparam int ENTRY_W = $bits(trk_entry_t);

   // Writes to x0 are discarded, so they never need forwarding.
   function automatic logic is_producer(input logic [31:0] inst);
      logic [4:0] op;
      op = inst[6:2];
      return (inst[1:0] == 2'b11) && (inst[11:7] != 5'd0) &&
             (op inside {OP_R, OP_I, OP_L, OP_JALR, OP_JAL, OP_AUIPC, OP_LUI});
   endfunction

   function automatic logic reads_rs1(input logic [31:0] inst);
      logic [4:0] op;
      op = inst[6:2];
      return op inside {OP_R, OP_I, OP_L, OP_S, OP_B, OP_JALR, OP_CSR};
   endfunction

   function automatic logic reads_rs2(input logic [31:0] inst);
      logic [4:0] op;
      op = inst[6:2];
      return op inside {OP_R, OP_S, OP_B};
   endfunction

endpackage

// File: rtl/fwd_tracker.sv
// Shift register of in-flight destination records; slot 0 is stage 1 (the stage right after decode).
module fwd_tracker
   import riscv_ctrl_pkg::*;
#(
   parameter int NUM_FWD_STAGES = 2,
   parameter int FLUSH_DEPTH    = 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              push,
   input  logic                              flush,
   input  logic [ENTRY_W-1:0]                entry,
   output logic [NUM_FWD_STAGES*ENTRY_W-1:0] entries
);

   logic [NUM_FWD_STAGES-1:0][ENTRY_W-1:0] stg;

   always_ff @(posedge clk) begin
      if (rst) begin
         stg <= '0;
      end else begin
         stg[0] <= (push && !flush) ? entry : '0;
         // A flush squashes the youngest FLUSH_DEPTH-1 older slots as they advance.
         for (int j = 1; j < NUM_FWD_STAGES; j++)
            stg[j] <= (flush && (j < FLUSH_DEPTH)) ? '0 : stg[j-1];
      end
   end

   assign entries = stg;

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Decode-stage load-use stall and operand-forward select controller.
// Optional HAZARD_FWD_PERF_CNT_EN adds saturating stall/forward event counters.
module hazard_forward_ctrl
   import riscv_ctrl_pkg::*;
#(
   parameter int NUM_FWD_STAGES = 2,
   parameter int LOAD_LAT       = 1,
   parameter int FLUSH_DEPTH    = 1,
   parameter int SEL_W          = $clog2(NUM_FWD_STAGES + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      inst,
   input  logic             inst_valid,
   input  logic             flush,
   output logic             stall,
   output logic             stall_q,
   output logic [SEL_W-1:0] fwd_sel_a,
   output logic [SEL_W-1:0] fwd_sel_b,
   output logic [SEL_W-1:0] fwd_sel_a_q,
   output logic [SEL_W-1:0] fwd_sel_b_q
`ifdef HAZARD_FWD_PERF_CNT_EN
   ,
   output logic [31:0]      stall_cycles,
   output logic [31:0]      fwd_events
`endif
);

   localparam int TW = NUM_FWD_STAGES * ENTRY_W;

   logic [TW-1:0]  entries;
   logic [SEL_W:0] pick_a, pick_b;
   trk_entry_t     dec_entry;
   logic           push;

   // Returns {unresolved, select}; scanning oldest to youngest lets the youngest match win.
   function automatic logic [SEL_W:0] pick(input logic [4:0] rs, input logic en,
                                           input logic [TW-1:0] ents);
      trk_entry_t       e;
      logic [SEL_W-1:0] sel;
      logic             unres;
      sel   = '0;
      unres = 1'b0;
      for (int k = NUM_FWD_STAGES; k >= 1; k--) begin
         e = ents[(k-1)*ENTRY_W +: ENTRY_W];
         if (en && (rs != 5'd0) && e.valid && (e.rd == rs)) begin
            unres = e.is_load && (k <= LOAD_LAT);
            sel   = unres ? '0 : SEL_W'(k);
         end
      end
      return {unres, sel};
   endfunction

   assign dec_entry = {is_producer(inst), inst[11:7], inst[6:2] == OP_L};
   assign pick_a    = pick(inst[19:15], reads_rs1(inst), entries);
   assign pick_b    = pick(inst[24:20], reads_rs2(inst), entries);

   assign stall     = inst_valid & ~flush & (pick_a[SEL_W] | pick_b[SEL_W]);
   assign fwd_sel_a = flush ? '0 : pick_a[SEL_W-1:0];
   assign fwd_sel_b = flush ? '0 : pick_b[SEL_W-1:0];
   assign push      = inst_valid & ~stall;

   fwd_tracker #(
      .NUM_FWD_STAGES (NUM_FWD_STAGES),
      .FLUSH_DEPTH    (FLUSH_DEPTH)
   ) u_trk (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .flush   (flush),
      .entry   (dec_entry),
      .entries (entries)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q     <= 1'b0;
         fwd_sel_a_q <= '0;
         fwd_sel_b_q <= '0;
      end else begin
         stall_q     <= stall;
         fwd_sel_a_q <= (stall || flush) ? '0 : fwd_sel_a;
         fwd_sel_b_q <= (stall || flush) ? '0 : fwd_sel_b;
      end
   end

`ifdef HAZARD_FWD_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles <= '0;
         fwd_events   <= '0;
      end else begin
         if (stall && (stall_cycles != 32'hFFFF_FFFF))
            stall_cycles <= stall_cycles + 32'd1;
         if (((fwd_sel_a != '0) || (fwd_sel_b != '0)) && !flush && (fwd_events != 32'hFFFF_FFFF))
            fwd_events <= fwd_events + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Self-checking bench for hazard_forward_ctrl: directed scenarios plus randomized traffic against an in-bench history model.
module tb_hazard_forward_ctrl;

   localparam int NF = 3;
   localparam int LL = 2;
   localparam int FD = 2;
   localparam int SW = $clog2(NF + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          inst_valid = 1'b0;
   logic          flush = 1'b0;
   logic [31:0]   inst = '0;
   logic          stall, stall_q;
   logic [SW-1:0] fwd_sel_a, fwd_sel_b, fwd_sel_a_q, fwd_sel_b_q;
`ifdef HAZARD_FWD_PERF_CNT_EN
   logic [31:0]   stall_cycles, fwd_events;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit         v;
      logic [4:0] rd;
      bit         ld;
   } rec_t;

   rec_t   hist[$];          // hist[0] is the instruction one stage past decode
   bit     model_ok = 1'b0;
   bit     m_stall_q;
   int     m_sa_q, m_sb_q;
   longint m_sc, m_fe;

   hazard_forward_ctrl #(
      .NUM_FWD_STAGES (NF),
      .LOAD_LAT       (LL),
      .FLUSH_DEPTH    (FD)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .inst        (inst),
      .inst_valid  (inst_valid),
      .flush       (flush),
      .stall       (stall),
      .stall_q     (stall_q),
      .fwd_sel_a   (fwd_sel_a),
      .fwd_sel_b   (fwd_sel_b),
      .fwd_sel_a_q (fwd_sel_a_q),
      .fwd_sel_b_q (fwd_sel_b_q)
`ifdef HAZARD_FWD_PERF_CNT_EN
      ,
      .stall_cycles (stall_cycles),
      .fwd_events   (fwd_events)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit b_prod(input logic [31:0] i);
      return (i[11:7] != 5'd0) &&
             (i[6:0] inside {7'h33, 7'h13, 7'h03, 7'h67, 7'h6F, 7'h17, 7'h37});
   endfunction

   function automatic bit b_rs1(input logic [31:0] i);
      return i[6:2] inside {5'h0C, 5'h04, 5'h00, 5'h08, 5'h18, 5'h19, 5'h1C};
   endfunction

   function automatic bit b_rs2(input logic [31:0] i);
      return i[6:2] inside {5'h0C, 5'h08, 5'h18};
   endfunction

   function automatic void mdl_pick(input logic [4:0] rs, input bit en,
                                    output int sel, output bit unres);
      bit found;
      found = 1'b0;
      sel   = 0;
      unres = 1'b0;
      if (en && rs != 5'd0)
         for (int i = 0; i < hist.size(); i++)
            if (!found && hist[i].v && hist[i].rd == rs) begin
               found = 1'b1;
               if (hist[i].ld && (i + 1) <= LL) unres = 1'b1;
               else sel = i + 1;
            end
   endfunction

   function automatic void mdl_eval(output bit st, output int sa, output int sb);
      bit ua, ub;
      mdl_pick(inst[19:15], b_rs1(inst), sa, ua);
      mdl_pick(inst[24:20], b_rs2(inst), sb, ub);
      st = inst_valid && !flush && (ua || ub);
      if (flush) begin
         sa = 0;
         sb = 0;
      end
   endfunction

   // Inputs only change just after posedge, so the negedge view is what the next edge samples.
   always @(negedge clk) begin
      bit   st;
      int   sa, sb;
      rec_t ne;
      mdl_eval(st, sa, sb);
      if (model_ok) begin
         chk("stall", stall, st);
         chk("fwd_sel_a", fwd_sel_a, sa);
         chk("fwd_sel_b", fwd_sel_b, sb);
         chk("stall_q", stall_q, m_stall_q);
         chk("fwd_sel_a_q", fwd_sel_a_q, m_sa_q);
         chk("fwd_sel_b_q", fwd_sel_b_q, m_sb_q);
`ifdef HAZARD_FWD_PERF_CNT_EN
         chk("stall_cycles", stall_cycles, m_sc);
         chk("fwd_events", fwd_events, m_fe);
`endif
      end
      if (rst) begin
         hist.delete();
         m_stall_q = 1'b0;
         m_sa_q    = 0;
         m_sb_q    = 0;
         m_sc      = 0;
         m_fe      = 0;
         model_ok  = 1'b1;
      end else begin
         m_stall_q = st;
         m_sa_q    = (st || flush) ? 0 : sa;
         m_sb_q    = (st || flush) ? 0 : sb;
         if (st && m_sc != 64'hFFFF_FFFF) m_sc++;
         if ((sa != 0 || sb != 0) && !flush && m_fe != 64'hFFFF_FFFF) m_fe++;
         if (flush)
            for (int i = 0; i < FD - 1 && i < hist.size(); i++) hist[i].v = 1'b0;
         ne.v  = inst_valid && !st && !flush && b_prod(inst);
         ne.rd = inst[11:7];
         ne.ld = (inst[6:0] == 7'h03);
         hist.push_front(ne);
         if (hist.size() > NF) void'(hist.pop_back());
      end
   end

   function automatic logic [31:0] enc_r(input int rd, input int rs1, input int rs2);
      return {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'h33};
   endfunction
   function automatic logic [31:0] enc_i(input int rd, input int rs1);
      return {12'd7, 5'(rs1), 3'b000, 5'(rd), 7'h13};
   endfunction
   function automatic logic [31:0] enc_lw(input int rd, input int rs1);
      return {12'd4, 5'(rs1), 3'b010, 5'(rd), 7'h03};
   endfunction
   function automatic logic [31:0] enc_lui(input int rd);
      return {20'h12345, 5'(rd), 7'h37};
   endfunction
   function automatic logic [31:0] enc_beq(input int rs1, input int rs2);
      return {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'b01000, 7'h63};
   endfunction

   function automatic logic [31:0] rnd_inst();
      logic [31:0] i;
      i = $urandom;
      i[11:7]  = 5'($urandom_range(0, 3));
      i[19:15] = 5'($urandom_range(0, 3));
      i[24:20] = 5'($urandom_range(0, 3));
      case ($urandom_range(0, 10))
         0: i[6:0] = 7'h33;
         1: i[6:0] = 7'h13;
         2: i[6:0] = 7'h03;
         3: i[6:0] = 7'h03;
         4: i[6:0] = 7'h23;
         5: i[6:0] = 7'h63;
         6: i[6:0] = 7'h67;
         7: i[6:0] = 7'h6F;
         8: i[6:0] = 7'h17;
         9: i[6:0] = 7'h37;
         default: i[6:0] = 7'h73;
      endcase
      if ($urandom_range(0, 15) == 0) i[1:0] = 2'($urandom_range(0, 2));
      return i;
   endfunction

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic clear();
      inst_valid = 1'b0;
      flush      = 1'b0;
      repeat (NF + 1) next();
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_stall", stall, 0);
      chk("rst_stall_q", stall_q, 0);
      chk("rst_sel_a_q", fwd_sel_a_q, 0);
      chk("rst_sel_b_q", fwd_sel_b_q, 0);
      next();
      rst = 1'b0;

      // ALU producer forwarded from stage 1
      clear();
      inst = enc_r(5, 1, 2); inst_valid = 1'b1; next();
      inst = enc_r(6, 5, 7);
      @(negedge clk);
      chk("t1_stall", stall, 0);
      chk("t1_sel_a", fwd_sel_a, 1);
      chk("t1_sel_b", fwd_sel_b, 0);
      next(); inst_valid = 1'b0;
      @(negedge clk);
      chk("t1_sel_a_q", fwd_sel_a_q, 1);

      // Load-use on a branch: two stall cycles, then bypass from stage 3
      clear();
      inst = enc_lw(3, 1); inst_valid = 1'b1; next();
      inst = enc_beq(3, 0);
      @(negedge clk); chk("t2_stall_c1", stall, 1);
      next();
      @(negedge clk); chk("t2_stall_c2", stall, 1); chk("t2_stall_q_c2", stall_q, 1);
      next();
      @(negedge clk);
      chk("t2_stall_c3", stall, 0);
      chk("t2_sel_a", fwd_sel_a, 3);
      chk("t2_sel_b", fwd_sel_b, 0);
      chk("t2_stall_q_c3", stall_q, 1);
      next(); inst_valid = 1'b0;
      @(negedge clk); chk("t2_sel_a_q", fwd_sel_a_q, 3);

      // Load-use on both operands
      clear();
      inst = enc_lw(5, 1); inst_valid = 1'b1; next();
      inst = enc_r(6, 5, 5);
      next(); next();
      @(negedge clk);
      chk("t2b_stall", stall, 0);
      chk("t2b_sel_a", fwd_sel_a, 3);
      chk("t2b_sel_b", fwd_sel_b, 3);

      // Youngest producer wins
      clear();
      inst = enc_i(4, 1); inst_valid = 1'b1; next();
      inst = enc_lui(4); next();
      inst = enc_r(1, 4, 0);
      @(negedge clk);
      chk("t3_sel_a", fwd_sel_a, 1);
      chk("t3_sel_b", fwd_sel_b, 0);

      // Flush during load-use stall also squashes the stage-1 load (FLUSH_DEPTH=2)
      clear();
      inst = enc_lw(5, 1); inst_valid = 1'b1; next();
      inst = enc_r(6, 5, 0); flush = 1'b1;
      @(negedge clk);
      chk("t4_stall_flush", stall, 0);
      chk("t4_sel_a_flush", fwd_sel_a, 0);
      next(); flush = 1'b0; inst = enc_r(7, 5, 0);
      @(negedge clk);
      chk("t4_stall_after", stall, 0);
      chk("t4_sel_a_after", fwd_sel_a, 0);

      // Reset during an active stall
      clear();
      inst = enc_lw(5, 1); inst_valid = 1'b1; next();
      inst = enc_r(6, 5, 5);
      @(negedge clk); chk("t5_stall_c1", stall, 1);
      next(); rst = 1'b1;
      @(negedge clk); chk("t5_stall_c2", stall, 1);
      next(); rst = 1'b0;
      @(negedge clk);
      chk("t5_stall", stall, 0);
      chk("t5_stall_q", stall_q, 0);
      chk("t5_sel_a", fwd_sel_a, 0);
      chk("t5_sel_b", fwd_sel_b, 0);
      chk("t5_sel_a_q", fwd_sel_a_q, 0);
      chk("t5_sel_b_q", fwd_sel_b_q, 0);
`ifdef HAZARD_FWD_PERF_CNT_EN
      chk("t5_stall_cycles", stall_cycles, 0);
      chk("t5_fwd_events", fwd_events, 0);
`endif

      // Randomized traffic; the consumer is usually held while stalled
      repeat (3000) begin
         next();
         rst        = ($urandom_range(0, 99) == 0);
         flush      = ($urandom_range(0, 9) == 0);
         inst_valid = ($urandom_range(0, 6) != 0);
         if (!stall || $urandom_range(0, 3) == 0) inst = rnd_inst();
      end

      next();
      rst = 1'b0; flush = 1'b0; inst_valid = 1'b0;
      next();
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
